// File: rtl/apogee_pkg.sv
// Shared constants, reset-sequencer state encoding and sizing helper for the
// Apogee system controller.
package apogee_pkg;

    localparam int APOGEE_CPU_DIV       = 28;
    localparam int APOGEE_CPU_DIV_TURBO = 14;
    localparam int APOGEE_F2_PHASE      = 2;
    localparam int APOGEE_PIX_DIV       = 6;
    localparam int APOGEE_INIT_DELAY    = 20000000;
    localparam int APOGEE_RST_STRETCH   = 15;

    typedef enum logic [1:0] {
        ST_POWERON,
        ST_HOLD,
        ST_STRETCH,
        ST_RUN
    } rst_state_e;

    // Bits needed to hold every value 0..max_val (at least one bit).
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/apogee_sysctl_if.sv
// Reset requests, speed/address inputs and every enable/reset output of the
// system controller, bundled for the system top.
interface apogee_sysctl_if;

    logic rst_req;
    logic download;
    logic turbo;
    logic a15;
    logic sys_reset;
    logic startup;
    logic f1;
    logic f2;
    logic ce_pix;
    logic ce_pix2x;
    logic ce_io;
    logic turbo_active;

    modport master (
        output rst_req, download, turbo, a15,
        input  sys_reset, startup, f1, f2, ce_pix, ce_pix2x, ce_io, turbo_active
    );

    modport slave (
        input  rst_req, download, turbo, a15,
        output sys_reset, startup, f1, f2, ce_pix, ce_pix2x, ce_io, turbo_active
    );

endinterface

// File: rtl/ce_divider.sv
// Wrapping 0..mod-1 counter with two registered tap pulses and a combinational
// wrap strobe that marks the last count of the period.
module ce_divider #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] mod_i,
    input  logic [W-1:0] tap_a_i,
    input  logic [W-1:0] tap_b_i,
    output logic         pulse_a_o,
    output logic         pulse_b_o,
    output logic         wrap_o
);

    localparam logic [W-1:0] ONE = W'(1);

    logic [W-1:0] cnt_q, cnt_d;
    logic         pulse_a_q, pulse_a_d;
    logic         pulse_b_q, pulse_b_d;

    assign wrap_o = (cnt_q == (mod_i - ONE));

    always_comb begin
        cnt_d     = wrap_o ? '0 : cnt_q + ONE;
        pulse_a_d = (cnt_q == tap_a_i);
        pulse_b_d = (cnt_q == tap_b_i);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            pulse_a_q <= 1'b0;
            pulse_b_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            pulse_a_q <= pulse_a_d;
            pulse_b_q <= pulse_b_d;
        end
    end

    assign pulse_a_o = pulse_a_q;
    assign pulse_b_o = pulse_b_q;

endmodule

// File: rtl/apogee_sysctl.sv
// Apogee timing and reset controller: CPU/pixel/IO clock enables, power-on
// delay, reset stretch and boot-ROM overlay flag.
//
//   state      | meaning
//   ST_POWERON | power-on delay still counting, sys_reset held
//   ST_HOLD    | user request or download holding sys_reset
//   ST_STRETCH | sources gone, stretch counter running, sys_reset held
//   ST_RUN     | stretch complete, sys_reset released
module apogee_sysctl
    import apogee_pkg::*;
#(
    parameter int CPU_DIV       = APOGEE_CPU_DIV,
    parameter int CPU_DIV_TURBO = APOGEE_CPU_DIV_TURBO,
    parameter int F2_PHASE      = APOGEE_F2_PHASE,
    parameter int PIX_DIV       = APOGEE_PIX_DIV,
    parameter int INIT_DELAY    = APOGEE_INIT_DELAY,
    parameter int RST_STRETCH   = APOGEE_RST_STRETCH,
    parameter int HOLD_ON_DL    = 1
) (
    input  logic           clk,
    input  logic           reset,
    apogee_sysctl_if.slave bus
);

    localparam int CPU_MAX = (CPU_DIV > CPU_DIV_TURBO) ? CPU_DIV : CPU_DIV_TURBO;
    localparam int CPU_MIN = (CPU_DIV < CPU_DIV_TURBO) ? CPU_DIV : CPU_DIV_TURBO;
    localparam int CPU_W   = cnt_width(CPU_MAX);
    localparam int PIX_W   = cnt_width(PIX_DIV);
    localparam int INIT_W  = cnt_width(INIT_DELAY);
    localparam int STR_W   = cnt_width(RST_STRETCH);

    localparam logic [INIT_W-1:0] INIT_LOAD = INIT_W'(INIT_DELAY);
    localparam logic [INIT_W-1:0] INIT_ONE  = INIT_W'(1);
    localparam logic [STR_W-1:0]  STR_MAX   = STR_W'(RST_STRETCH);
    localparam logic [STR_W-1:0]  STR_ONE   = STR_W'(1);
    localparam logic              HOLD_DL   = (HOLD_ON_DL != 0);

    if (CPU_DIV < 4 || CPU_DIV_TURBO < 4 || F2_PHASE < 1 || F2_PHASE >= CPU_MIN ||
        PIX_DIV < 2 || (PIX_DIV % 2) != 0 || RST_STRETCH < 1) begin : g_param_check
        $error("apogee_sysctl: illegal parameter combination");
    end

    logic [INIT_W-1:0] init_q, init_d;
    logic [STR_W-1:0]  stretch_q, stretch_d;
    rst_state_e        state_q, state_d;
    logic              startup_q, startup_d;
    logic              turbo_active_q, turbo_active_d;
    logic              ce_io_q;

    logic              src;
    logic              sys_reset;
    logic [CPU_W-1:0]  cpu_mod;
    logic              cpu_wrap;
    logic              f1_pulse, f2_pulse;
    logic              pix_wrap;
    logic              pix_full, pix_half;

    // Power-on delay freezes while an image is being downloaded.
    always_comb begin
        init_d = init_q;
        if (init_q != '0 && !bus.download) begin
            init_d = init_q - INIT_ONE;
        end
    end

    assign src = bus.rst_req | (init_q != '0) | (HOLD_DL & bus.download);

    always_comb begin
        state_d   = state_q;
        stretch_d = stretch_q;
        if (src) begin
            stretch_d = '0;
            state_d   = (init_q != '0) ? ST_POWERON : ST_HOLD;
        end else if (stretch_q != STR_MAX) begin
            stretch_d = stretch_q + STR_ONE;
            state_d   = ST_STRETCH;
        end else begin
            state_d   = ST_RUN;
        end
    end

    assign sys_reset = (state_q != ST_RUN);

    always_comb begin
        startup_d      = sys_reset | (startup_q & ~bus.a15);
        turbo_active_d = cpu_wrap ? bus.turbo : turbo_active_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            init_q         <= INIT_LOAD;
            stretch_q      <= '0;
            state_q        <= ST_POWERON;
            startup_q      <= 1'b1;
            turbo_active_q <= 1'b0;
            ce_io_q        <= 1'b0;
        end else begin
            init_q         <= init_d;
            stretch_q      <= stretch_d;
            state_q        <= state_d;
            startup_q      <= startup_d;
            turbo_active_q <= turbo_active_d;
            ce_io_q        <= ~ce_io_q;
        end
    end

    // Modulus only changes together with the wrap, so every period is whole.
    assign cpu_mod = turbo_active_q ? CPU_W'(CPU_DIV_TURBO) : CPU_W'(CPU_DIV);

    ce_divider #(.W(CPU_W)) u_cpu_div (
        .clk       (clk),
        .rst       (reset),
        .mod_i     (cpu_mod),
        .tap_a_i   (CPU_W'(0)),
        .tap_b_i   (CPU_W'(F2_PHASE)),
        .pulse_a_o (f1_pulse),
        .pulse_b_o (f2_pulse),
        .wrap_o    (cpu_wrap)
    );

    ce_divider #(.W(PIX_W)) u_pix_div (
        .clk       (clk),
        .rst       (reset),
        .mod_i     (PIX_W'(PIX_DIV)),
        .tap_a_i   (PIX_W'(PIX_DIV - 1)),
        .tap_b_i   (PIX_W'(PIX_DIV / 2 - 1)),
        .pulse_a_o (pix_full),
        .pulse_b_o (pix_half),
        .wrap_o    (pix_wrap)
    );

    a_pix_align : assert property (@(posedge clk) disable iff (reset) pix_wrap |=> pix_full);

    assign bus.sys_reset    = sys_reset;
    assign bus.startup      = startup_q;
    assign bus.f1           = f1_pulse;
    assign bus.f2           = f2_pulse;
    assign bus.ce_pix       = pix_full;
    assign bus.ce_pix2x     = pix_full | pix_half;
    assign bus.ce_io        = ce_io_q;
    assign bus.turbo_active = turbo_active_q;

endmodule

// File: tb/tb_apogee_sysctl.sv
// Scoreboard bench for apogee_sysctl: two instances differing only in
// download hold, short power-on delay, expected events queued per stream.
module tb_apogee_sysctl;

    typedef struct {
        int   cyc;
        logic val;
    } ev_t;

    localparam int NS        = 5;
    localparam int S_RST_A   = 0;
    localparam int S_RST_B   = 1;
    localparam int S_START_A = 2;
    localparam int S_F1      = 3;
    localparam int S_F2      = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic rst_req = 1'b0, download = 1'b0, turbo = 1'b0, a15 = 1'b0;
    int   cyc;
    int   n_checks = 0;
    int   n_fail = 0;
    bit   f1_chk = 1'b0;
    ev_t  exp_q[NS][$];
    string sname[NS] = '{"sys_reset_a", "sys_reset_b", "startup_a", "f1", "f2"};
    logic prev_rst_a, prev_rst_b, prev_start_a;

    apogee_sysctl_if ifa ();
    apogee_sysctl_if ifb ();

    assign ifa.rst_req  = rst_req;
    assign ifa.download = download;
    assign ifa.turbo    = turbo;
    assign ifa.a15      = a15;
    assign ifb.rst_req  = rst_req;
    assign ifb.download = download;
    assign ifb.turbo    = turbo;
    assign ifb.a15      = a15;

    apogee_sysctl #(.INIT_DELAY(100), .HOLD_ON_DL(1)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (ifa)
    );

    apogee_sysctl #(.INIT_DELAY(100), .HOLD_ON_DL(0)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (ifb)
    );

    always #5 clk = ~clk;

    always @(posedge clk or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    task automatic chk(input string nm, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0b, required %0b (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic push(input int s, input int c, input logic v);
        ev_t e;
        e.cyc = c;
        e.val = v;
        exp_q[s].push_back(e);
    endtask

    task automatic sb_event(input int s, input logic v);
        ev_t e;
        n_checks++;
        if (exp_q[s].size() == 0) begin
            n_fail++;
            $display("FAIL %s: unexpected value %0b at cycle %0d, no event required", sname[s], v, cyc);
        end else begin
            e = exp_q[s].pop_front();
            if (e.cyc != cyc || e.val !== v) begin
                n_fail++;
                $display("FAIL %s: got %0b at cycle %0d, required %0b at cycle %0d",
                         sname[s], v, cyc, e.val, e.cyc);
            end
        end
    endtask

    task automatic sb_expire();
        ev_t e;
        for (int s = 0; s < NS; s++) begin
            while (exp_q[s].size() > 0 && exp_q[s][0].cyc < cyc) begin
                e = exp_q[s].pop_front();
                n_checks++;
                n_fail++;
                $display("FAIL %s: nothing seen by cycle %0d, required %0b at cycle %0d",
                         sname[s], cyc, e.val, e.cyc);
            end
        end
    endtask

    task automatic drain(input string tag);
        ev_t e;
        for (int s = 0; s < NS; s++) begin
            while (exp_q[s].size() > 0) begin
                e = exp_q[s].pop_front();
                n_checks++;
                n_fail++;
                $display("FAIL %s %s: event never seen, required %0b at cycle %0d",
                         tag, sname[s], e.val, e.cyc);
            end
        end
    endtask

    task automatic wait_cyc(input int k);
        while (cyc < k) @(negedge clk);
    endtask

    // Monitor: turns output changes/pulses into events and pops the scoreboard.
    always @(negedge clk) begin
        if (reset) begin
            prev_rst_a   <= ifa.sys_reset;
            prev_rst_b   <= ifb.sys_reset;
            prev_start_a <= ifa.startup;
        end else begin
            sb_expire();
            if (ifa.sys_reset !== prev_rst_a) sb_event(S_RST_A, ifa.sys_reset);
            if (ifb.sys_reset !== prev_rst_b) sb_event(S_RST_B, ifb.sys_reset);
            if (ifa.startup !== prev_start_a) sb_event(S_START_A, ifa.startup);
            prev_rst_a   <= ifa.sys_reset;
            prev_rst_b   <= ifb.sys_reset;
            prev_start_a <= ifa.startup;
            if (f1_chk && ifa.f1 === 1'b1) sb_event(S_F1, 1'b1);
            if (f1_chk && ifa.f2 === 1'b1) sb_event(S_F2, 1'b1);
            if (cyc >= 1) begin
                chk("ce_pix",   ifa.ce_pix,   (cyc % 6) == 0);
                chk("ce_pix2x", ifa.ce_pix2x, (cyc % 3) == 0);
                chk("ce_io",    ifa.ce_io,    cyc[0]);
            end
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        reset = 1'b0;
        push(S_RST_A, 116, 1'b0);
        push(S_RST_B, 116, 1'b0);

        f1_chk = 1'b1;
        push(S_F1, 1, 1'b1);  push(S_F1, 29, 1'b1);  push(S_F1, 57, 1'b1);
        push(S_F2, 3, 1'b1);  push(S_F2, 31, 1'b1);  push(S_F2, 59, 1'b1);
        wait_cyc(60);
        f1_chk = 1'b0;

        wait_cyc(120);
        a15 = 1'b1;
        push(S_START_A, 121, 1'b0);
        wait_cyc(121);
        a15 = 1'b0;

        wait_cyc(130);
        rst_req = 1'b1;
        push(S_RST_A, 131, 1'b1);  push(S_RST_A, 147, 1'b0);
        push(S_RST_B, 131, 1'b1);  push(S_RST_B, 147, 1'b0);
        push(S_START_A, 132, 1'b1);
        wait_cyc(131);
        rst_req = 1'b0;

        wait_cyc(160);
        f1_chk = 1'b1;
        push(S_F1, 169, 1'b1);  push(S_F1, 197, 1'b1);  push(S_F1, 211, 1'b1);
        push(S_F1, 225, 1'b1);  push(S_F1, 239, 1'b1);  push(S_F1, 253, 1'b1);
        push(S_F2, 171, 1'b1);  push(S_F2, 199, 1'b1);  push(S_F2, 213, 1'b1);
        push(S_F2, 227, 1'b1);  push(S_F2, 241, 1'b1);  push(S_F2, 255, 1'b1);
        wait_cyc(178);
        turbo = 1'b1;
        wait_cyc(195);
        chk("turbo_active_before_wrap", ifa.turbo_active, 1'b0);
        wait_cyc(196);
        chk("turbo_active_after_wrap", ifa.turbo_active, 1'b1);
        wait_cyc(258);
        f1_chk = 1'b0;

        wait_cyc(270);
        a15 = 1'b1;
        push(S_START_A, 271, 1'b0);
        wait_cyc(271);
        a15 = 1'b0;

        wait_cyc(309);
        drain("run1");
        reset = 1'b1;
        #1;
        chk("async_sys_reset",    ifa.sys_reset,    1'b1);
        chk("async_startup",      ifa.startup,      1'b1);
        chk("async_f1",           ifa.f1,           1'b0);
        chk("async_f2",           ifa.f2,           1'b0);
        chk("async_ce_pix",       ifa.ce_pix,       1'b0);
        chk("async_ce_pix2x",     ifa.ce_pix2x,     1'b0);
        chk("async_ce_io",        ifa.ce_io,        1'b0);
        chk("async_turbo_active", ifa.turbo_active, 1'b0);
        turbo = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        push(S_RST_A, 166, 1'b0);
        push(S_RST_B, 166, 1'b0);

        wait_cyc(40);
        download = 1'b1;
        wait_cyc(90);
        download = 1'b0;

        wait_cyc(200);
        download = 1'b1;
        push(S_RST_A, 201, 1'b1);  push(S_RST_A, 221, 1'b0);
        wait_cyc(205);
        download = 1'b0;

        wait_cyc(230);
        download = 1'b1;
        rst_req  = 1'b1;
        push(S_RST_A, 231, 1'b1);  push(S_RST_A, 256, 1'b0);
        push(S_RST_B, 231, 1'b1);  push(S_RST_B, 251, 1'b0);
        wait_cyc(235);
        rst_req = 1'b0;
        wait_cyc(240);
        download = 1'b0;

        wait_cyc(270);
        drain("run2");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
